// File: rtl/seven_seg_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scanner_if
// Purpose  : Host-side data/strobe and display-side drive signals of the scanner.
// Revision : 1.0
// ============================================================================
interface seven_seg_scanner_if;
  logic        enable;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic [1:0]  digit_sel;
  logic        frame_done;

  modport master (
    output enable, value, load, dp_in,
    input  an, seg, dp_n, digit_sel, frame_done
  );

  modport slave (
    input  enable, value, load, dp_in,
    output an, seg, dp_n, digit_sel, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scanner
// Purpose  : 4-digit multiplexed 7-segment scanner with blanking gaps and
//            frame-synchronous (tear-free) display updates.
//            Option: SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision : 1.0
// ============================================================================
module seven_seg_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  seven_seg_scanner_if.slave  bus
);

  localparam int MAX_CYC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_n_q, dp_n_d;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       disp_val_q, disp_val_d;
  logic [3:0]        disp_dp_q, disp_dp_d;
  logic [15:0]       pend_val_q, pend_val_d;
  logic [3:0]        pend_dp_q, pend_dp_d;
  logic              pend_valid_q, pend_valid_d;

  logic              commit;
  logic [3:0]        lz_blank;
  logic [3:0]        cur_digit;
  logic              cur_dp;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = (disp_val_q[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (disp_val_q[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (disp_val_q[7:4]  == 4'h0);
  end
`else
  always_comb begin
    lz_blank = 4'b0000;
  end
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;

    // Display contents only change between frames or while dark.
    commit = (state_q == ST_OFF) || frame_done_q;

    if (bus.load) begin
      pend_val_d   = bus.value;
      pend_dp_d    = bus.dp_in;
      pend_valid_d = 1'b1;
    end

    if (commit) begin
      if (bus.load) begin
        disp_val_d = bus.value;
        disp_dp_d  = bus.dp_in;
      end else if (pend_valid_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
      pend_valid_d = 1'b0;
    end

    if (!bus.enable) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      sel_d   = 2'd0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          sel_d   = 2'd0;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            sel_d   = sel_q + 2'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
          sel_d   = 2'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    an_d         = 4'b1111;
    seg_d        = 7'b1111111;
    dp_n_d       = 1'b1;
    frame_done_d = 1'b0;
    cur_digit    = disp_val_q[{sel_d, 2'b00} +: 4];
    cur_dp       = disp_dp_q[sel_d];

    if (state_d == ST_DRIVE) begin
      if (lz_blank[sel_d]) begin
        if (cur_dp) begin
          an_d   = ~(4'b0001 << sel_d);
          dp_n_d = 1'b0;
        end
      end else begin
        an_d   = ~(4'b0001 << sel_d);
        seg_d  = hex_to_seg(cur_digit);
        dp_n_d = ~cur_dp;
      end
      frame_done_d = (sel_d == 2'd3) && (cnt_d == DRIVE_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      sel_q        <= 2'd0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
      disp_val_q   <= 16'h0000;
      disp_dp_q    <= 4'b0000;
      pend_val_q   <= 16'h0000;
      pend_dp_q    <= 4'b0000;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.digit_sel  = sel_q;
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, DRIVE slot length per digit in clk cycles (min 2; 1 kHz/digit at 100 MHz).
REQ-002 Parameter BLANK_CYCLES, default 1000, all-anodes-off gap before each digit in clk cycles (min 1).
REQ-003 clk  input  1  system clock, rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  1 = scan display; 0 = display dark.
REQ-006 value  input  16  four hex digits; digit n = value[4n+3:4n], digit 0 rightmost.
REQ-007 load  input  1  one-cycle strobe; capture value and dp_in into pending register.
REQ-008 dp_in  input  4  decimal point request per digit, active-high.
REQ-009 an  output  4  anode enables, active-low, one-hot-low or 4'b1111.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp_n  output  1  decimal point, active-low.
REQ-012 digit_sel  output  2  index of current digit; an equals the active-low 2-to-4 decode of digit_sel while driving.
REQ-013 frame_done  output  1  one-cycle pulse at end of digit 3 DRIVE slot.

Function
REQ-014 FSM states OFF, BLANK, DRIVE; all outputs registered.
REQ-015 OFF: an=1111, seg=1111111, dp_n=1, digit_sel=0, counter=0; go BLANK the cycle after enable sampled 1.
REQ-016 BLANK: an=1111, seg=1111111, dp_n=1 for exactly BLANK_CYCLES cycles, then DRIVE.
REQ-017 DRIVE: an active for digit_sel, seg/dp_n from displayed register, exactly REFRESH_DIV cycles; then digit_sel increments mod 4 (3 wraps to 0) and go BLANK.
REQ-018 Frame period = 4*(REFRESH_DIV+BLANK_CYCLES) cycles; frame_done asserts on the last DRIVE cycle of digit 3 only.
REQ-019 Hex encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 load captures value/dp_in into pending and sets pending_valid; later load before commit overwrites pending.
REQ-021 Commit (displayed <= pending, pending_valid cleared) only on the frame_done cycle or any cycle in OFF; no tearing mid-frame.
REQ-022 load coincident with a commit cycle: the coincident value/dp_in is committed directly.
REQ-023 enable deasserted in any state: next cycle OFF with REQ-015 outputs; no frame_done; pending retained.
REQ-024 Re-enable always restarts at digit 0 with a full BLANK interval.

Reset
REQ-025 rst has priority over all inputs: state OFF, counter 0, digit_sel 0, an=1111, seg=1111111, dp_n=1, frame_done=0, displayed=0, dp=0, pending=0, pending_valid=0.
REQ-026 rst mid-frame takes effect next edge; no partial digit after release.

Configuration
REQ-027 Macro SEVEN_SEG_LEADING_ZERO_BLANK_EN: defined -> digit n>0 is blanked (seg=1111111) when it and all higher digits are 0; digit 0 never blanked; blanked digit keeps anode off unless its dp bit is set; slot timing unchanged.
REQ-028 Macro undefined -> all four digits always shown, leading zeros displayed as 0.

Verification (REFRESH_DIV=4, BLANK_CYCLES=2)
REQ-029 rst=1 for 3 cycles, enable=1 -> an=1111, seg=1111111, dp_n=1, frame_done=0 throughout reset.
REQ-030 In OFF load value=16'h1234, dp_in=4'b0010, enable=1 -> 2 cycles an=1111, 4 cycles an=1110 seg=0011001, 2 blank, 4 cycles an=1101 seg=0110000 dp_n=0.
REQ-031 load 16'hABCD during digit 1 DRIVE -> digits 2,3 still show 2,1; next frame digit 0 shows 0100001 (d); commit coincides with frame_done.
REQ-032 enable=0 during digit 2 DRIVE -> next cycle an=1111, digit_sel=0; enable=1 -> 2 blank cycles then an=1110.
REQ-033 frame_done: exactly one pulse per 24 cycles while enabled; none when enable=0.
REQ-034 With SEVEN_SEG_LEADING_ZERO_BLANK_EN, value 16'h0050 -> digit 3,2 slots an=1111, digit 1 seg=0010010, digit 0 seg=1000000; value 16'h0000 -> only digit 0 shows 1000000.
